// File: rtl/sap_pkg.sv
// Shared sequencer package: FSM state encoding, step-width helper and the
// control-word bit positions the parent uses to drive i_adv / i_halt.
// Optional feature macro used by this block: STEP_MODE_EN.
package sap_pkg;

   typedef enum logic [1:0] {
      SEQ_RUN   = 2'd0,
      SEQ_HALT  = 2'd1,
      SEQ_PAUSE = 2'd2
   } seq_state_t;

   // Control-word bits that the parent routes to i_adv and i_halt.
   localparam int ADV_POS = 0;
   localparam int HLT_POS = 1;

   // Width of the microstep index; never below one bit.
   function automatic int step_w(input int steps);
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Decoder-side bus of the micro sequencer: control-word feedback from the
// decoder (adv/halt/wait) and the step index / datapath enable back to it.
// master = sequencer side, slave = decoder/datapath side.
interface micro_sequencer_if
   import sap_pkg::*;
#(
   parameter int STEPS = 8
) ();

   logic                      i_adv;
   logic                      i_halt;
   logic                      i_wait;
   logic [step_w(STEPS)-1:0]  o_step;
   logic                      o_cycle_en;

   modport master (
      input  i_adv,
      input  i_halt,
      input  i_wait,
      output o_step,
      output o_cycle_en
   );

   modport slave (
      output i_adv,
      output i_halt,
      output i_wait,
      input  o_step,
      input  o_cycle_en
   );

endinterface

// File: rtl/micro_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

   // Count up on inc until all-ones, clear wins.
   always_ff @(posedge clk) begin
      if (clear)
         count <= '0;
      else if (inc && (count != MAX))
         count <= count + WIDTH'(1);
   end

endmodule

// File: rtl/micro_sequencer.sv
// Micro sequencer: steps the decoder through the microsteps of each
// instruction, stalls on memory wait, halts on HLT, counts retired
// instructions and lost cycles.
// Optional feature macro: STEP_MODE_EN (pause / single-instruction step).
module micro_sequencer
   import sap_pkg::*;
#(
   parameter int INSTRUCTION_STEPS = 8,
   parameter int RETIRE_WIDTH      = 16,
   parameter int STALL_WIDTH       = 8
) (
   input  logic                    clk,
   input  logic                    i_reset,
   input  logic                    clk_en,
   input  logic                    i_run,
   input  logic                    i_step,
   micro_sequencer_if.master       bus,
   output logic                    o_halted,
   output logic                    o_paused,
   output logic [RETIRE_WIDTH-1:0] o_retired,
   output logic [STALL_WIDTH-1:0]  o_stalls
);

   localparam int               STEP_W = step_w(INSTRUCTION_STEPS);
   localparam logic [STEP_W-1:0] LAST  = STEP_W'(INSTRUCTION_STEPS - 1);

   seq_state_t        state, state_nx;
   logic [STEP_W-1:0] step, step_nx;
   logic              retire;
   logic              stall_inc;

`ifdef STEP_MODE_EN
   // Set when a single step has been granted; cleared once i_step is seen
   // low, so a held i_step yields only one instruction.
   logic armed, armed_nx;
`else
   logic unused_step_mode;
   assign unused_step_mode = ^{i_run, i_step};
`endif

   // State register: step index, FSM state and retire counter.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         state     <= SEQ_RUN;
         step      <= '0;
         o_retired <= '0;
      end else begin
         state <= state_nx;
         step  <= step_nx;
         if (retire)
            o_retired <= o_retired + RETIRE_WIDTH'(1);
      end
   end

`ifdef STEP_MODE_EN
   // Single-step grant flag.
   always_ff @(posedge clk) begin
      if (i_reset)
         armed <= 1'b0;
      else
         armed <= armed_nx;
   end
`endif

   // Next-state logic; nothing moves on cycles without clk_en.
   always_comb begin
      state_nx  = state;
      step_nx   = step;
      retire    = 1'b0;
      stall_inc = 1'b0;
`ifdef STEP_MODE_EN
      armed_nx  = armed;
`endif
      if (clk_en) begin
`ifdef STEP_MODE_EN
         if (!i_step)
            armed_nx = 1'b0;
`endif
         case (state)
            SEQ_RUN: begin
               if (bus.i_wait) begin
                  // Wait beats halt and adv: the step is simply re-presented.
                  stall_inc = 1'b1;
               end else if (bus.i_halt) begin
                  // Halt beats adv; step and counters freeze.
                  state_nx = SEQ_HALT;
               end else if (bus.i_adv || (step == LAST)) begin
                  step_nx = '0;
                  retire  = 1'b1;
`ifdef STEP_MODE_EN
                  if (!i_run)
                     state_nx = SEQ_PAUSE;
`endif
               end else begin
                  step_nx = step + STEP_W'(1);
               end
            end
`ifdef STEP_MODE_EN
            SEQ_PAUSE: begin
               if (i_run) begin
                  state_nx = SEQ_RUN;
               end else if (i_step && !armed) begin
                  // Run one instruction; the retiring edge brings us back
                  // here because i_run is still low.
                  state_nx = SEQ_RUN;
                  armed_nx = 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   sat_counter #(
      .WIDTH (STALL_WIDTH)
   ) u_stalls (
      .clk   (clk),
      .clear (i_reset),
      .inc   (stall_inc),
      .count (o_stalls)
   );

   assign bus.o_step     = step;
   assign bus.o_cycle_en = clk_en & (state == SEQ_RUN) & ~bus.i_wait;
   assign o_halted       = (state == SEQ_HALT);
`ifdef STEP_MODE_EN
   assign o_paused       = (state == SEQ_PAUSE);
`else
   assign o_paused       = 1'b0;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer (INSTRUCTION_STEPS=6): directed
// scenarios followed by random traffic, compared every cycle against a
// behavioural model of the sequencing rules.
module tb_micro_sequencer;

   localparam int STEPS = 6;
`ifdef STEP_MODE_EN
   localparam bit SM = 1'b1;
`else
   localparam bit SM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, cen, run, stp;
   logic        halted, paused;
   logic [15:0] retired;
   logic [7:0]  stalls;

   micro_sequencer_if #(.STEPS(STEPS)) bus ();

   micro_sequencer #(
      .INSTRUCTION_STEPS (STEPS),
      .RETIRE_WIDTH      (16),
      .STALL_WIDTH       (8)
   ) dut (
      .clk       (clk),
      .i_reset   (rst),
      .clk_en    (cen),
      .i_run     (run),
      .i_step    (stp),
      .bus       (bus),
      .o_halted  (halted),
      .o_paused  (paused),
      .o_retired (retired),
      .o_stalls  (stalls)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model
   int m_step, m_ret, m_stall;
   bit m_halt, m_pause, m_armed, m_valid;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_step = 0; m_ret = 0; m_stall = 0;
         m_halt = 0; m_pause = 0; m_armed = 0; m_valid = 1;
         return;
      end
      if (!cen) return;
      if (SM && !stp) m_armed = 0;
      if (m_halt) begin
         // stuck until reset
      end else if (m_pause) begin
         if (run) m_pause = 0;
         else if (stp && !m_armed) begin m_pause = 0; m_armed = 1; end
      end else if (bus.i_wait) begin
         if (m_stall < 255) m_stall++;
      end else if (bus.i_halt) begin
         m_halt = 1;
      end else if (bus.i_adv || m_step == STEPS - 1) begin
         m_step = 0;
         m_ret  = (m_ret + 1) % 65536;
         if (SM && !run) m_pause = 1;
      end else begin
         m_step++;
      end
   endtask

   task automatic tick();
      #1;
      if (m_valid)
         chk("cycle_en", bus.o_cycle_en,
             (cen && !m_halt && !m_pause && !bus.i_wait) ? 32'd1 : 32'd0);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("step",    bus.o_step, m_step);
      chk("halted",  halted,     m_halt);
      chk("paused",  paused,     m_pause);
      chk("retired", retired,    m_ret);
      chk("stalls",  stalls,     m_stall);
   endtask

   task automatic idle_inputs();
      rst = 0; cen = 1; run = 1; stp = 0;
      bus.i_adv = 0; bus.i_halt = 0; bus.i_wait = 0;
   endtask

   int saved;

   initial begin
      m_valid = 0;
      idle_inputs();
      @(negedge clk);

      // reset
      rst = 1; tick(); rst = 0;
      chk("reset_step", bus.o_step, 0);
      chk("reset_ret", retired, 0);

      // three instructions ending at step 4
      for (int i = 0; i < 15; i++) begin
         bus.i_adv = (m_step == 4);
         tick();
      end
      bus.i_adv = 0;
      chk("three_instr_ret", retired, 3);
      chk("three_instr_step", bus.o_step, 0);

      // natural wrap at STEPS-1
      repeat (12) tick();
      chk("wrap_ret", retired, 5);

      // wait at step 2 for four enabled cycles
      rst = 1; tick(); rst = 0;
      repeat (2) tick();
      bus.i_wait = 1;
      repeat (4) tick();
      chk("wait_step", bus.o_step, 2);
      chk("wait_stalls", stalls, 4);
      bus.i_wait = 0;
      tick();
      chk("resume_step", bus.o_step, 3);

      // clk_en low one cycle in four
      for (int i = 0; i < 16; i++) begin
         cen = (i % 4) != 3;
         bus.i_adv = ($urandom % 3) == 0;
         tick();
      end
      cen = 1; bus.i_adv = 0;

      // halt and adv at step 3 held off by wait
      rst = 1; tick(); rst = 0;
      repeat (3) tick();
      saved = m_ret;
      bus.i_halt = 1; bus.i_adv = 1; bus.i_wait = 1;
      repeat (2) tick();
      chk("halt_held_by_wait", halted, 0);
      bus.i_wait = 0;
      tick();
      chk("halt_taken", halted, 1);
      chk("halt_step", bus.o_step, 3);
      chk("halt_ret", retired, saved);
      for (int i = 0; i < 100; i++) begin
         cen = $urandom_range(0, 1); bus.i_adv = $urandom_range(0, 1);
         bus.i_wait = $urandom_range(0, 1); bus.i_halt = $urandom_range(0, 1);
         tick();
      end
      chk("halt_stays", halted, 1);
      idle_inputs();

      // reset with clk_en low in the middle of a stall
      rst = 1; tick(); rst = 0;
      tick();
      bus.i_wait = 1;
      repeat (3) tick();
      rst = 1; cen = 0;
      tick();
      chk("reset_nocen_stalls", stalls, 0);
      chk("reset_nocen_step", bus.o_step, 0);
      rst = 0; cen = 1;

      // stall counter saturation
      repeat (260) tick();
      chk("stall_sat", stalls, 255);
      idle_inputs();

`ifdef STEP_MODE_EN
      // pause after the current instruction
      rst = 1; tick(); rst = 0;
      repeat (2) tick();
      run = 0;
      for (int k = 0; k < 20 && !m_pause; k++) tick();
      chk("pause_entered", paused, 1);
      chk("pause_step", bus.o_step, 0);
      saved = m_ret;
      stp = 1;
      repeat (10) tick();
      chk("single_step_ret", retired, (saved + 1) % 65536);
      chk("single_step_paused", paused, 1);
      stp = 0; tick();
      run = 1;
      repeat (8) tick();
      chk("free_run", paused, 0);
`endif

      // random traffic
      rst = 1; tick(); rst = 0;
      for (int i = 0; i < 600; i++) begin
         rst        = (($urandom % 80) == 0) || (m_halt && ($urandom % 8) == 0);
         cen        = ($urandom % 4) != 0;
         bus.i_adv  = ($urandom % 4) == 0;
         bus.i_wait = ($urandom % 4) == 0;
         bus.i_halt = ($urandom % 40) == 0;
         run        = ($urandom % 6) != 0;
         stp        = ($urandom % 3) == 0;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
